// File: rtl/bus_slot_scheduler_if.sv
// bus_slot_scheduler_if
// Groups the signals between the bus slot scheduler and its neighbours
// (68000 interface, video timer, RAM/ROM address mux).
//   master : drives the requests and CPU strobe, observes schedule/grants
//   slave  : the scheduler itself
// Signals:
//   _cpuAS          CPU address strobe, active low
//   cpuSelRAM       CPU access targets RAM
//   videoReq        video wants the next slot 0
//   soundReq        sound wants the next slot 0
//   extraReq        extra-ROM read request (level, held until acked)
//   busCycle        frame phase 0..3
//   videoBusControl high during busCycle 0
//   slotOwner       slot-0 owner: 0 idle, 1 video, 2 sound, 3 extra
//   extraAck        one-clock extra-ROM grant
//   _cpuDTACK       CPU data acknowledge, active low
//   cpuStrobe       one-clock pulse on first DTACK clock of an access
//   extraStarve     slots an extra request has waited (saturating)
interface bus_slot_scheduler_if #(
    parameter int unsigned STARVE_W = 8
) ();
    logic                _cpuAS;
    logic                cpuSelRAM;
    logic                videoReq;
    logic                soundReq;
    logic                extraReq;
    logic [1:0]          busCycle;
    logic                videoBusControl;
    logic [1:0]          slotOwner;
    logic                extraAck;
    logic                _cpuDTACK;
    logic                cpuStrobe;
    logic [STARVE_W-1:0] extraStarve;

    modport master (
        output _cpuAS, cpuSelRAM, videoReq, soundReq, extraReq,
        input  busCycle, videoBusControl, slotOwner, extraAck, _cpuDTACK, cpuStrobe,
               extraStarve
    );

    modport slave (
        input  _cpuAS, cpuSelRAM, videoReq, soundReq, extraReq,
        output busCycle, videoBusControl, slotOwner, extraAck, _cpuDTACK, cpuStrobe,
               extraStarve
    );
endinterface

// File: rtl/bus_slot_scheduler.sv
// bus_slot_scheduler
// Sequences the shared RAM/ROM bus over a 4-clock frame: runs the frame phase
// counter, arbitrates the slot-0 window (video > sound > extra ROM), and
// generates CPU /DTACK with RAM_WAIT extra frames for RAM plus a one-clock
// access strobe.
// Ports:
//   clk8    8.125 MHz bus clock
//   _reset  asynchronous active-low reset
//   bus     bus_slot_scheduler_if.slave (requests in, schedule/acks out)
// Parameters:
//   RAM_WAIT  extra whole frames (0..15) before /DTACK on RAM accesses
//   STARVE_W  width of the extra-ROM starvation counter
module bus_slot_scheduler #(
    parameter int unsigned RAM_WAIT = 1,
    parameter int unsigned STARVE_W = 8
) (
    input logic                  clk8,
    input logic                  _reset,
    bus_slot_scheduler_if.slave  bus
);

    localparam logic [3:0] WaitInit = 4'(RAM_WAIT);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAck
    } dtack_state_e;

    dtack_state_e        r_state;
    logic [3:0]          r_cnt;
    logic [1:0]          r_bus_cycle;
    logic                r_video_bus;
    logic [1:0]          r_slot_owner;
    logic                r_extra_ack;
    logic                r_dtack_n;
    logic                r_strobe;
    logic [STARVE_W-1:0] r_starve;

    logic [1:0]          w_next_owner;

    // Fixed priority for the upcoming slot 0; nothing is queued.
    always_comb begin
        w_next_owner = 2'd0;
        if (bus.videoReq) begin
            w_next_owner = 2'd1;
        end else if (bus.soundReq) begin
            w_next_owner = 2'd2;
        end else if (bus.extraReq) begin
            w_next_owner = 2'd3;
        end
    end

    always_ff @(posedge clk8 or negedge _reset) begin
        if (!_reset) begin
            r_state      <= StIdle;
            r_cnt        <= 4'd0;
            r_bus_cycle  <= 2'd0;
            r_video_bus  <= 1'b1;
            r_slot_owner <= 2'd0;
            r_extra_ack  <= 1'b0;
            r_dtack_n    <= 1'b1;
            r_strobe     <= 1'b0;
            r_starve     <= '0;
        end else begin
            r_bus_cycle <= r_bus_cycle + 2'd1;
            r_video_bus <= (r_bus_cycle == 2'd3);
            r_extra_ack <= 1'b0;
            r_strobe    <= 1'b0;

            // Slot-0 decision is made on the edge into busCycle 0.
            if (r_bus_cycle == 2'd3) begin
                r_slot_owner <= w_next_owner;
                r_extra_ack  <= (w_next_owner == 2'd3);
                if (!bus.extraReq || (w_next_owner == 2'd3)) begin
                    r_starve <= '0;
                end else if (r_starve != '1) begin
                    r_starve <= r_starve + STARVE_W'(1);
                end
            end

            unique case (r_state)
                StIdle: begin
                    // Arming only from IDLE means AS must have been seen high
                    // (ACK exit) before another access can be acknowledged.
                    if ((r_bus_cycle == 2'd1) && !bus._cpuAS) begin
                        if (!bus.cpuSelRAM || (RAM_WAIT == 0)) begin
                            r_state   <= StAck;
                            r_dtack_n <= 1'b0;
                            r_strobe  <= 1'b1;
                        end else begin
                            r_state <= StWait;
                            r_cnt   <= WaitInit;
                        end
                    end
                end
                StWait: begin
                    if (bus._cpuAS) begin
                        // Aborted cycle.
                        r_state <= StIdle;
                        r_cnt   <= 4'd0;
                    end else if (r_bus_cycle == 2'd1) begin
                        r_cnt <= r_cnt - 4'd1;
                        if (r_cnt == 4'd1) begin
                            r_state   <= StAck;
                            r_dtack_n <= 1'b0;
                            r_strobe  <= 1'b1;
                        end
                    end
                end
                StAck: begin
                    if (bus._cpuAS) begin
                        r_state   <= StIdle;
                        r_dtack_n <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= StIdle;
                    r_dtack_n <= 1'b1;
                end
            endcase
        end
    end

    assign bus.busCycle        = r_bus_cycle;
    assign bus.videoBusControl = r_video_bus;
    assign bus.slotOwner       = r_slot_owner;
    assign bus.extraAck        = r_extra_ack;
    assign bus._cpuDTACK       = r_dtack_n;
    assign bus.cpuStrobe       = r_strobe;
    assign bus.extraStarve     = r_starve;

endmodule

// File: tb/tb_bus_slot_scheduler.sv
// tb_bus_slot_scheduler
// Self-checking bench for bus_slot_scheduler: a hand-computed vector table,
// hand-written multi-cycle sequences, and randomized stimulus compared against
// a timestamp-based reference model.
module tb_bus_slot_scheduler;

    localparam int unsigned RAM_WAIT  = 1;
    localparam int unsigned STARVE_W  = 8;
    localparam int          STARVE_MX = (1 << STARVE_W) - 1;

    logic clk8   = 1'b0;
    logic _reset = 1'b1;

    bus_slot_scheduler_if #(.STARVE_W(STARVE_W)) bus ();

    bus_slot_scheduler #(
        .RAM_WAIT (RAM_WAIT),
        .STARVE_W (STARVE_W)
    ) dut (
        .clk8   (clk8),
        ._reset (_reset),
        .bus    (bus)
    );

    always #5 clk8 = ~clk8;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Time is counted in edges since reset release; a pending RAM access
    // carries the edge number at which it will be acknowledged.
    int m_n, m_owner, m_starve, m_due;
    bit m_wait, m_ack, m_strobe, m_xack;

    task automatic model_reset();
        m_n = 0; m_owner = 0; m_starve = 0; m_due = 0;
        m_wait = 0; m_ack = 0; m_strobe = 0; m_xack = 0;
    endtask

    task automatic model_edge(input bit as, input bit sel, input bit v, input bit s,
                              input bit x);
        int bc;
        bc = m_n % 4;
        m_strobe = 0;
        if (m_ack) begin
            if (as) m_ack = 0;
        end else if (m_wait) begin
            if (as) m_wait = 0;
            else if (m_n + 1 == m_due) begin
                m_wait = 0; m_ack = 1; m_strobe = 1;
            end
        end else if (bc == 1 && !as) begin
            if (sel && RAM_WAIT > 0) begin
                m_wait = 1;
                m_due  = m_n + 1 + 4 * int'(RAM_WAIT);
            end else begin
                m_ack = 1; m_strobe = 1;
            end
        end
        m_xack = 0;
        if (bc == 3) begin
            m_owner = v ? 1 : s ? 2 : x ? 3 : 0;
            m_xack  = (m_owner == 3);
            if (!x || m_owner == 3) m_starve = 0;
            else if (m_starve < STARVE_MX) m_starve++;
        end
        m_n++;
    endtask

    task automatic model_check();
        chk("busCycle", 32'(bus.busCycle), 32'(m_n % 4));
        chk("videoBusControl", 32'(bus.videoBusControl), 32'((m_n % 4) == 0));
        chk("slotOwner", 32'(bus.slotOwner), 32'(m_owner));
        chk("extraAck", 32'(bus.extraAck), 32'(m_xack));
        chk("_cpuDTACK", 32'(bus._cpuDTACK), 32'(!m_ack));
        chk("cpuStrobe", 32'(bus.cpuStrobe), 32'(m_strobe));
        chk("extraStarve", 32'(bus.extraStarve), 32'(m_starve));
    endtask

    // One clock: inputs are those held before the edge; outputs sampled 1 after.
    task automatic tick();
        bit as, sel, v, s, x;
        as = bus._cpuAS; sel = bus.cpuSelRAM; v = bus.videoReq;
        s = bus.soundReq; x = bus.extraReq;
        @(posedge clk8);
        model_edge(as, sel, v, s, x);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " busCycle"}, 32'(bus.busCycle), 32'd0);
        chk({tag, " videoBusControl"}, 32'(bus.videoBusControl), 32'd1);
        chk({tag, " slotOwner"}, 32'(bus.slotOwner), 32'd0);
        chk({tag, " extraAck"}, 32'(bus.extraAck), 32'd0);
        chk({tag, " _cpuDTACK"}, 32'(bus._cpuDTACK), 32'd1);
        chk({tag, " cpuStrobe"}, 32'(bus.cpuStrobe), 32'd0);
        chk({tag, " extraStarve"}, 32'(bus.extraStarve), 32'd0);
    endtask

    // Asserts reset mid-cycle, checks immediately, releases mid-cycle.
    task automatic apply_reset(input string tag);
        #2;
        _reset = 1'b0;
        model_reset();
        #1;
        check_reset_vals({tag, " in reset"});
        repeat (2) @(posedge clk8);
        #1;
        _reset = 1'b1;
        #1;
        check_reset_vals({tag, " released"});
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       as, sel, v, s, x;
        logic [1:0] bc, owner;
        logic       xack, dtack, strobe;
        logic [7:0] starve;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input logic as, sel, v, s, x, input logic [1:0] bc, owner,
                                input logic xack, dtack, strobe, input logic [7:0] starve);
        vec_t r;
        r.as = as; r.sel = sel; r.v = v; r.s = s; r.x = x;
        r.bc = bc; r.owner = owner; r.xack = xack; r.dtack = dtack;
        r.strobe = strobe; r.starve = starve;
        return r;
    endfunction

    initial begin
        int strobes;
        //              as sel v  s  x   bc owner xack dtack strobe starve
        vecs[0]  = mk(0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0);  // ROM access starts
        vecs[1]  = mk(0, 0, 0, 0, 0,  2, 0, 0, 0, 1, 0);  // ROM ack at bc2
        vecs[2]  = mk(0, 0, 0, 0, 0,  3, 0, 0, 0, 0, 0);
        vecs[3]  = mk(1, 0, 1, 0, 1,  0, 1, 0, 1, 0, 1);  // AS high; video beats extra
        vecs[4]  = mk(0, 1, 0, 0, 1,  1, 1, 0, 1, 0, 1);  // RAM access
        vecs[5]  = mk(0, 1, 0, 0, 1,  2, 1, 0, 1, 0, 1);  // waiting
        vecs[6]  = mk(0, 1, 0, 0, 1,  3, 1, 0, 1, 0, 1);
        vecs[7]  = mk(0, 1, 0, 0, 1,  0, 3, 1, 1, 0, 0);  // extra granted
        vecs[8]  = mk(0, 1, 0, 0, 1,  1, 3, 0, 1, 0, 0);
        vecs[9]  = mk(0, 1, 0, 0, 0,  2, 3, 0, 0, 1, 0);  // RAM ack 4 clocks later
        vecs[10] = mk(0, 1, 0, 0, 0,  3, 3, 0, 0, 0, 0);
        vecs[11] = mk(1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0);  // idle slot

        bus._cpuAS = 1'b1; bus.cpuSelRAM = 1'b0;
        bus.videoReq = 1'b0; bus.soundReq = 1'b0; bus.extraReq = 1'b0;
        #3;
        apply_reset("init");

        // Table-driven vectors.
        for (int i = 0; i < 12; i++) begin
            bus._cpuAS = vecs[i].as; bus.cpuSelRAM = vecs[i].sel;
            bus.videoReq = vecs[i].v; bus.soundReq = vecs[i].s; bus.extraReq = vecs[i].x;
            tick();
            chk($sformatf("vec%0d busCycle", i), 32'(bus.busCycle), 32'(vecs[i].bc));
            chk($sformatf("vec%0d vbc", i), 32'(bus.videoBusControl),
                32'(vecs[i].bc == 2'd0));
            chk($sformatf("vec%0d slotOwner", i), 32'(bus.slotOwner), 32'(vecs[i].owner));
            chk($sformatf("vec%0d extraAck", i), 32'(bus.extraAck), 32'(vecs[i].xack));
            chk($sformatf("vec%0d dtack", i), 32'(bus._cpuDTACK), 32'(vecs[i].dtack));
            chk($sformatf("vec%0d strobe", i), 32'(bus.cpuStrobe), 32'(vecs[i].strobe));
            chk($sformatf("vec%0d starve", i), 32'(bus.extraStarve), 32'(vecs[i].starve));
        end

        // RAM access with AS held 3 extra frames: one strobe, DTACK stays low.
        apply_reset("hold");
        bus._cpuAS = 1'b0; bus.cpuSelRAM = 1'b1;
        repeat (5) tick();
        chk("hold pre-ack dtack", 32'(bus._cpuDTACK), 32'd1);
        tick();
        chk("hold ack dtack", 32'(bus._cpuDTACK), 32'd0);
        chk("hold ack strobe", 32'(bus.cpuStrobe), 32'd1);
        chk("hold ack busCycle", 32'(bus.busCycle), 32'd2);
        strobes = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.cpuStrobe) strobes++;
            chk("hold dtack low", 32'(bus._cpuDTACK), 32'd0);
        end
        chk("hold extra strobes", 32'(strobes), 32'd0);
        bus._cpuAS = 1'b1;
        tick();
        chk("hold release dtack", 32'(bus._cpuDTACK), 32'd1);

        // Starvation: sound keeps winning for 300 frames.
        bus.soundReq = 1'b1; bus.extraReq = 1'b1; bus._cpuAS = 1'b0; bus.cpuSelRAM = 1'b0;
        repeat (300 * 4) tick();
        chk("starve saturated", 32'(bus.extraStarve), 32'(STARVE_MX));
        chk("starve owner", 32'(bus.slotOwner), 32'd2);
        chk("starve dtack", 32'(bus._cpuDTACK), 32'd0);

        // Reset mid-operation with requests still pending, then count phases.
        repeat (2) tick();
        apply_reset("midop");
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("post-reset busCycle", 32'(bus.busCycle), 32'(k % 4));
        end
        chk("post-reset owner", 32'(bus.slotOwner), 32'd2);
        bus.soundReq = 1'b0; bus.extraReq = 1'b0; bus._cpuAS = 1'b1;

        // Reset during WAIT, then a fresh RAM access at normal latency.
        apply_reset("wait");
        bus._cpuAS = 1'b0; bus.cpuSelRAM = 1'b1;
        repeat (3) tick();
        apply_reset("in-wait");
        repeat (5) tick();
        chk("wait no early ack", 32'(bus._cpuDTACK), 32'd1);
        tick();
        chk("wait ack dtack", 32'(bus._cpuDTACK), 32'd0);
        chk("wait ack strobe", 32'(bus.cpuStrobe), 32'd1);
        bus._cpuAS = 1'b1;
        tick();

        // Randomized traffic against the reference model.
        apply_reset("rand");
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(5) == 0) bus._cpuAS = ~bus._cpuAS;
            if ($urandom_range(7) == 0) bus.cpuSelRAM = 1'($urandom_range(1));
            bus.videoReq = ($urandom_range(3) == 0);
            bus.soundReq = ($urandom_range(4) == 0);
            if ($urandom_range(3) == 0) bus.extraReq = ~bus.extraReq;
            tick();
            model_check();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
